// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed hex driver for a common-anode 7-segment display.
// The value is latched once per frame so a scan never shows mixed digits.
module seg7_scan #(
  parameter int CLK_DIV = 100000,
  parameter int DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  en,
  input  logic                  hold,
  input  logic                  lzb,
  input  logic [DIGITS-1:0]     dp,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic                  frame_start
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [CW-1:0]         div_cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   shadow;
  logic                  tick;
  logic                  last;
  logic [3:0]            nib;
  logic                  dp_cur;
  logic [IW-1:0]         top;
  logic                  blank;
  logic [DIGITS-1:0]     an_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick   = (div_cnt == DIV_MAX);
  assign last   = (idx == IDX_MAX);
  assign an_nxt = ~(DIGITS'(1) << idx);

  // top = highest nonzero nibble; digit 0 is always kept
  always_comb begin
    nib    = '0;
    dp_cur = 1'b0;
    top    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib    = shadow[4*i +: 4];
        dp_cur = dp[i];
      end
      if (shadow[4*i +: 4] != 4'h0) top = IW'(i);
    end
    blank = lzb && (idx > top);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt     <= '0;
      idx         <= '0;
      shadow      <= '0;
      frame_start <= 1'b0;
      an          <= '1;
      seg         <= 7'h7F;
      dp_n        <= 1'b1;
    end else begin
      div_cnt     <= tick ? '0 : div_cnt + 1'b1;
      frame_start <= tick && last;
      if (tick) begin
        if (last) begin
          idx <= '0;
          if (!hold) shadow <= value;
        end else begin
          idx <= idx + 1'b1;
        end
      end
      if (!en || blank) begin
        an   <= '1;
        seg  <= 7'h7F;
        dp_n <= 1'b1;
      end else begin
        an   <= an_nxt;
        seg  <= hex7(nib);
        dp_n <= ~dp_cur;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: scoreboard bench for seg7_scan, CLK_DIV=4, DIGITS=4.
// Stimulus queues per-slot expectations; a monitor samples mid-slot.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        en;
  logic        hold;
  logic        lzb;
  logic [3:0]  dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_start;

  seg7_scan #(.CLK_DIV(4), .DIGITS(4)) dut (
    .clk(clk), .rst(rst), .value(value), .en(en),
    .hold(hold), .lzb(lzb), .dp(dp), .an(an),
    .seg(seg), .dp_n(dp_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         f;
    int         s;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dpn;
  } exp_t;

  exp_t q[$];
  int   ncmp = 0;
  int   nbad = 0;
  int   frame = 0;
  bit   mon_go = 0;
  event fs_ev;

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] want);
    ncmp++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic ex(input int f, input int s, input logic [3:0] a,
                    input logic [6:0] sg, input logic d);
    exp_t e;
    e.f = f; e.s = s; e.an = a; e.seg = sg; e.dpn = d;
    q.push_back(e);
  endtask

  task automatic ex4(input int f, input logic [6:0] s0,
                     input logic [6:0] s1, input logic [6:0] s2,
                     input logic [6:0] s3);
    ex(f, 0, 4'b1110, s0, 1'b1);
    ex(f, 1, 4'b1101, s1, 1'b1);
    ex(f, 2, 4'b1011, s2, 1'b1);
    ex(f, 3, 4'b0111, s3, 1'b1);
  endtask

  task automatic blank(input int f, input int s);
    ex(f, s, 4'b1111, 7'h7F, 1'b1);
  endtask

  task automatic next_frame();
    bit got;
    got = 0;
    fork
      begin @(fs_ev); got = 1; end
      begin repeat (64) @(negedge clk); end
    join_any
    disable fork;
    if (!got) begin
      ncmp++;
      nbad++;
      $display("FAIL frame_timeout: got none expected frame_start");
    end
  endtask

  // monitor: frame period plus one mid-slot sample per digit slot
  initial begin
    int  since;
    int  slot;
    bit  have;
    exp_t e;
    since = 0;
    have  = 0;
    wait (mon_go);
    forever begin
      @(negedge clk);
      since++;
      if (frame_start) begin
        if (have) chk("frame_period", 16'(since), 16'd16);
        since = 0;
        have  = 1;
        frame++;
        ->fs_ev;
      end else if (have && since <= 14 && (since % 4) == 2) begin
        slot = (since - 2) / 4;
        while (q.size() > 0 && (q[0].f < frame ||
               (q[0].f == frame && q[0].s < slot))) begin
          e = q.pop_front();
          ncmp++;
          nbad++;
          $display("FAIL stale f%0d s%0d: got unsampled expected sampled",
                   e.f, e.s);
        end
        if (q.size() > 0 && q[0].f == frame && q[0].s == slot) begin
          e = q.pop_front();
          chk($sformatf("f%0d_s%0d {an,seg,dp_n}", frame, slot),
              16'({an, seg, dp_n}), 16'({e.an, e.seg, e.dpn}));
        end
      end
    end
  end

  initial begin
    rst   = 1'b1;
    value = 16'h1234;
    en    = 1'b1;
    hold  = 1'b0;
    lzb   = 1'b0;
    dp    = 4'b0000;
    repeat (2) @(negedge clk);
    chk("reset_out", 16'({an, seg, dp_n, frame_start}),
        16'({4'b1111, 7'h7F, 1'b1, 1'b0}));
    rst = 1'b0;
    @(negedge clk);
    chk("release_digit0", 16'({an, seg}), 16'({4'b1110, 7'h40}));
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset", 16'({an, seg, dp_n, frame_start}),
        16'({4'b1111, 7'h7F, 1'b1, 1'b0}));
    @(negedge clk);
    rst    = 1'b0;
    mon_go = 1;

    next_frame();
    ex4(frame, 7'h19, 7'h30, 7'h24, 7'h79);
    value = 16'h00A5;

    next_frame();
    lzb = 1'b1;
    ex(frame, 0, 4'b1110, 7'h12, 1'b1);
    ex(frame, 1, 4'b1101, 7'h08, 1'b1);
    blank(frame, 2);
    blank(frame, 3);
    value = 16'h0000;

    next_frame();
    ex(frame, 0, 4'b1110, 7'h40, 1'b1);
    blank(frame, 1);
    blank(frame, 2);
    blank(frame, 3);
    value = 16'h1234;

    next_frame();
    lzb = 1'b0;
    ex4(frame, 7'h19, 7'h30, 7'h24, 7'h79);
    hold  = 1'b1;
    value = 16'hABCD;

    for (int k = 0; k < 3; k++) begin
      next_frame();
      ex4(frame, 7'h19, 7'h30, 7'h24, 7'h79);
    end
    hold = 1'b0;

    next_frame();
    ex4(frame, 7'h21, 7'h46, 7'h03, 7'h08);
    repeat (6) @(negedge clk);
    value = 16'h5678;

    next_frame();
    ex4(frame, 7'h00, 7'h78, 7'h02, 7'h12);

    next_frame();
    ex(frame, 0, 4'b1110, 7'h00, 1'b1);
    blank(frame, 1);
    blank(frame, 2);
    blank(frame, 3);
    repeat (3) @(negedge clk);
    en = 1'b0;

    next_frame();
    blank(frame, 0);
    ex(frame, 1, 4'b1101, 7'h78, 1'b1);
    ex(frame, 2, 4'b1011, 7'h02, 1'b1);
    ex(frame, 3, 4'b0111, 7'h12, 1'b1);
    repeat (5) @(negedge clk);
    en = 1'b1;

    next_frame();
    dp    = 4'b0100;
    value = 16'h0005;
    ex(frame, 0, 4'b1110, 7'h00, 1'b1);
    ex(frame, 1, 4'b1101, 7'h78, 1'b1);
    ex(frame, 2, 4'b1011, 7'h02, 1'b0);
    ex(frame, 3, 4'b0111, 7'h12, 1'b1);

    next_frame();
    lzb = 1'b1;
    ex(frame, 0, 4'b1110, 7'h12, 1'b1);
    blank(frame, 1);
    blank(frame, 2);
    blank(frame, 3);

    next_frame();
    repeat (2) @(negedge clk);
    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
